// File: rtl/csa_word_sequencer.sv
// Sequences a WORD_W-bit add through one shared SLICE_W-bit adder slice, LSB slice first.
// Optional CSA_SEQ_OVF_EN adds a registered two's-complement overflow output (ovf).
module csa_word_sequencer #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  a,
  input  logic [WORD_W-1:0]  b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  sum,
  output logic               cout,
  output logic               busy,
  output logic [SLICE_W-1:0] add_x,
  output logic [SLICE_W-1:0] add_y,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic               add_cout
`ifdef CSA_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int unsigned NSLICE = WORD_W / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WORD_W % SLICE_W != 0) begin : g_bad_width
    $error("WORD_W must be a multiple of SLICE_W");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_a, r_b, r_sum;
  logic               r_carry, r_cout;
  logic               w_run, w_last;

  assign w_run  = (r_state == StRun);
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = w_run || out_valid;
  assign add_x     = w_run ? r_a[r_idx*SLICE_W +: SLICE_W] : '0;
  assign add_y     = w_run ? r_b[r_idx*SLICE_W +: SLICE_W] : '0;
  assign add_cin   = w_run ? r_carry : 1'b0;
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef CSA_SEQ_OVF_EN
  logic r_ovf;
  logic w_msb_cin;
  // Carry into the MSB recovered from the sum bit of the final slice.
  assign w_msb_cin = r_a[WORD_W-1] ^ r_b[WORD_W-1] ^ add_sum[SLICE_W-1];
  assign ovf       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_ovf <= 1'b0;
    else if (w_run && w_last) r_ovf <= w_msb_cin ^ add_cout;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        StRun: begin
          r_sum[r_idx*SLICE_W +: SLICE_W] <= add_sum;
          r_carry <= add_cout;
          if (w_last) begin
            r_cout <= add_cout;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) r_idx <= '0;
        end
        default: r_idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed plus random bench for csa_word_sequencer with a behavioural adder slice and
// an arithmetic reference model of the full-word add.
module tb_csa_word_sequencer;

  localparam int WORD_W  = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = WORD_W / SLICE_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               cin_i = 1'b0;
  logic [WORD_W-1:0]  a_i = '0;
  logic [WORD_W-1:0]  b_i = '0;
  logic               in_ready, out_valid, cout, busy, add_cin, add_cout;
  logic [WORD_W-1:0]  sum;
  logic [SLICE_W-1:0] add_x, add_y, add_sum;
`ifdef CSA_SEQ_OVF_EN
  logic               ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  csa_word_sequencer #(.WORD_W(WORD_W), .SLICE_W(SLICE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .cin      (cin_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
`ifdef CSA_SEQ_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Behavioural shared adder slice.
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{SLICE_W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
    check({tag, "_add_xyc"}, {47'd0, add_x, add_y, add_cin}, 64'd0);
  endtask

  // One complete transaction; abort_after >= 0 asserts rst after that many RUN edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int hold, input bit disturb, input int abort_after);
    logic [32:0] full;
    logic [63:0] mask;
    logic [63:0] exp_c;
    int          lat;
    int          w;
    int          low;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a_i = a; b_i = b; cin_i = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_i = $urandom; b_i = $urandom; cin_i = ~c;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < NSLICE) begin
        low   = lat * SLICE_W;
        mask  = (64'd1 << low) - 64'd1;
        exp_c = ((64'(a) & mask) + (64'(b) & mask) + 64'(c)) >> low;
        check("add_cin", 64'(add_cin), exp_c);
        check("add_x", 64'(add_x), (64'(a) >> low) & 64'hff);
        check("add_y", 64'(add_y), (64'(b) >> low) & 64'hff);
        check("in_ready_run", 64'(in_ready), 64'd0);
        check("busy_run", 64'(busy), 64'd1);
      end
      if (disturb) begin
        a_i = $urandom; b_i = $urandom; in_valid = 1'b1;
      end
      if (abort_after == lat) begin
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_during");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort_after");
        return;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(NSLICE));
    check("sum", 64'(sum), 64'(full[31:0]));
    check("cout", 64'(cout), 64'(full[32]));
`ifdef CSA_SEQ_OVF_EN
    check("ovf", 64'(ovf), 64'((a[31] == b[31]) && (full[31] != a[31])));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_sum", 64'(sum), 64'(full[31:0]));
      check("hold_cout", 64'(cout), 64'(full[32]));
      check("hold_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
    end
    // Offer a new operand on the release edge; it must not be taken.
    a_i = $urandom; b_i = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("release_busy", 64'(busy), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_sum_kept", 64'(sum), 64'(full[31:0]));
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_release");

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, -1);
    run_op(32'h12345678, 32'h11111111, 1'b1, 0, 1'b0, -1);
    run_op(32'hDEADBEEF, 32'h01020304, 1'b1, 5, 1'b0, -1);
    run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1, 1'b1, -1);
    run_op(32'h89ABCDEF, 32'h76543210, 1'b1, 0, 1'b0, 2);
    run_op(32'h00000003, 32'h00000004, 1'b0, 0, 1'b0, -1);
`ifdef CSA_SEQ_OVF_EN
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, -1);
    run_op(32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, -1);
`endif
    for (int k = 0; k < 20; k++) begin
      run_op($urandom, $urandom, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
             1'($urandom_range(1, 0)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
